// File: rtl/lab_buffer_scheduler.sv
// -----------------------------------------------------------------------------
// lab_buffer_scheduler
//
// Hands the four LAB sample buffers out to incoming triggers in strict
// round-robin order (0,1,2,3,0,...). It feeds the single LAB digitizer one
// buffer at a time. It presents the oldest digitized buffer to the PCI
// readout side until that side frees it.
//
// Three 3-bit pointers (2-bit buffer index plus a wrap bit) track the buffers:
//   wr : next buffer to allocate to a trigger
//   dg : next buffer to digitize
//   rd : oldest allocated buffer, next to be freed by readout
// The ordering rd <= dg <= wr always holds (mod 8). Occupancy is wr - rd.
//
// Optional feature, controlled by the macro LAB_SCHED_TIMEOUT_EN:
//   defined     : WAIT counts cycles. After DIG_TIMEOUT cycles without
//                 dig_done_i, the buffer is treated as digitized and
//                 timeout_o is set. timeout_o stays set until reset/clear.
//   not defined : WAIT is held until dig_done_i. timeout_o stays 0.
//
// Parameters
//   DIG_TIMEOUT  WAIT cycles before a digitization is forced complete (>= 2)
//   DROP_W       width of the saturating dropped-trigger counter
//
// Ports
//   clk_i        in   system clock
//   nrst_i       in   asynchronous reset, active low
//   clear_i      in   synchronous clear, same effect as reset
//   trig_i       in   1-cycle trigger pulse
//   trig_ack_o   out  1-cycle pulse: trigger given buffer trig_buf_o
//   trig_drop_o  out  1-cycle pulse: trigger dropped, all buffers occupied
//   trig_buf_o   out  allocated buffer index, valid with trig_ack_o
//   digitize_o   out  one-hot 1-cycle digitize request
//   dig_done_i   in   1-cycle pulse: digitizer finished the current buffer
//   rd_valid_o   out  oldest allocated buffer is digitized and readable
//   rd_buf_o     out  index of the oldest allocated buffer
//   rd_done_i    in   1-cycle pulse: readout finished, free rd_buf_o
//   occupancy_o  out  number of allocated buffers, 0..4
//   full_o       out  occupancy_o == 4
//   drop_cnt_o   out  saturating count of dropped triggers
//   timeout_o    out  sticky digitization-timeout flag
//   state_o      out  FSM state (IDLE=0, ISSUE=1, WAIT=2)
//
// All outputs are registered. Each output reflects the effect of an edge
// during the cycle that follows that edge.
// -----------------------------------------------------------------------------
module lab_buffer_scheduler #(
    parameter int DIG_TIMEOUT = 4095,
    parameter int DROP_W      = 16
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              clear_i,
    input  logic              trig_i,
    output logic              trig_ack_o,
    output logic              trig_drop_o,
    output logic [1:0]        trig_buf_o,
    output logic [3:0]        digitize_o,
    input  logic              dig_done_i,
    output logic              rd_valid_o,
    output logic [1:0]        rd_buf_o,
    input  logic              rd_done_i,
    output logic [2:0]        occupancy_o,
    output logic              full_o,
    output logic [DROP_W-1:0] drop_cnt_o,
    output logic              timeout_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};
    localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

    // A timeout shorter than two cycles cannot be honoured by the WAIT timer
    if (DIG_TIMEOUT < 2) begin : g_bad_timeout
        $error("lab_buffer_scheduler: DIG_TIMEOUT must be at least 2");
    end

    // Pointer and FSM state
    logic [2:0] wr_r;
    logic [2:0] dg_r;
    logic [2:0] rd_r;
    state_t     state_r;

`ifdef LAB_SCHED_TIMEOUT_EN
    localparam int             TMR_W    = $clog2(DIG_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DIG_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};
    localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};

    logic [TMR_W-1:0] timer_r;
    logic [TMR_W-1:0] timer_nxt_s;
`endif

    // Next-state values
    logic [2:0]        occ_s;
    logic              alloc_s;
    logic              drop_s;
    logic              free_s;
    logic [2:0]        wr_nxt_s;
    logic [2:0]        dg_nxt_s;
    logic [2:0]        rd_nxt_s;
    logic [2:0]        occ_nxt_s;
    state_t            state_nxt_s;
    logic [3:0]        digitize_nxt_s;
    logic [DROP_W-1:0] drop_cnt_nxt_s;
    logic              timeout_nxt_s;

    // Allocation, freeing and the drop counter, all based on registered occupancy
    always_comb begin
        occ_s   = wr_r - rd_r;
        // The decision uses the occupancy before any same-edge free, so a
        // trigger that arrives while full is dropped even if readout frees
        // a buffer on the same edge.
        alloc_s = trig_i && (occ_s < 3'd4);
        drop_s  = trig_i && !(occ_s < 3'd4);
        // A free is only honoured while a digitized buffer is presented
        free_s  = rd_done_i && (rd_r != dg_r);

        if (alloc_s) begin
            wr_nxt_s = wr_r + 3'd1;
        end else begin
            wr_nxt_s = wr_r;
        end

        if (free_s) begin
            rd_nxt_s = rd_r + 3'd1;
        end else begin
            rd_nxt_s = rd_r;
        end

        if (drop_s && (drop_cnt_o != DROP_MAX)) begin
            drop_cnt_nxt_s = drop_cnt_o + DROP_ONE;
        end else begin
            drop_cnt_nxt_s = drop_cnt_o;
        end

        occ_nxt_s = wr_nxt_s - rd_nxt_s;
    end

    // Digitizer sequencing: one outstanding digitization at a time
    always_comb begin
        state_nxt_s   = state_r;
        dg_nxt_s      = dg_r;
`ifdef LAB_SCHED_TIMEOUT_EN
        timeout_nxt_s = timeout_o;
        timer_nxt_s   = timer_r;
`else
        timeout_nxt_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                // dig_done_i is deliberately ignored outside WAIT
                if (dg_r != wr_r) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_WAIT;
`ifdef LAB_SCHED_TIMEOUT_EN
                timer_nxt_s = TMR_ZERO;
`endif
            end
            ST_WAIT: begin
                if (dig_done_i) begin
                    dg_nxt_s    = dg_r + 3'd1;
                    state_nxt_s = ST_IDLE;
                end
`ifdef LAB_SCHED_TIMEOUT_EN
                else if (timer_r == TMR_LAST) begin
                    // Give up on the digitizer and treat the buffer as done
                    dg_nxt_s      = dg_r + 3'd1;
                    state_nxt_s   = ST_IDLE;
                    timeout_nxt_s = 1'b1;
                end else begin
                    timer_nxt_s = timer_r + TMR_ONE;
                end
`else
                else begin
                    state_nxt_s = ST_WAIT;
                end
`endif
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // The request is raised for the single cycle spent in ISSUE
        if (state_nxt_s == ST_ISSUE) begin
            digitize_nxt_s = 4'b0001 << dg_r[1:0];
        end else begin
            digitize_nxt_s = 4'b0000;
        end
    end

    // State, pointers and registered outputs
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            wr_r        <= 3'd0;
            dg_r        <= 3'd0;
            rd_r        <= 3'd0;
            state_r     <= ST_IDLE;
`ifdef LAB_SCHED_TIMEOUT_EN
            timer_r     <= TMR_ZERO;
`endif
            trig_ack_o  <= 1'b0;
            trig_drop_o <= 1'b0;
            trig_buf_o  <= 2'd0;
            digitize_o  <= 4'd0;
            rd_valid_o  <= 1'b0;
            rd_buf_o    <= 2'd0;
            occupancy_o <= 3'd0;
            full_o      <= 1'b0;
            drop_cnt_o  <= {DROP_W{1'b0}};
            timeout_o   <= 1'b0;
            state_o     <= 2'd0;
        end else if (clear_i) begin
            wr_r        <= 3'd0;
            dg_r        <= 3'd0;
            rd_r        <= 3'd0;
            state_r     <= ST_IDLE;
`ifdef LAB_SCHED_TIMEOUT_EN
            timer_r     <= TMR_ZERO;
`endif
            trig_ack_o  <= 1'b0;
            trig_drop_o <= 1'b0;
            trig_buf_o  <= 2'd0;
            digitize_o  <= 4'd0;
            rd_valid_o  <= 1'b0;
            rd_buf_o    <= 2'd0;
            occupancy_o <= 3'd0;
            full_o      <= 1'b0;
            drop_cnt_o  <= {DROP_W{1'b0}};
            timeout_o   <= 1'b0;
            state_o     <= 2'd0;
        end else begin
            wr_r        <= wr_nxt_s;
            dg_r        <= dg_nxt_s;
            rd_r        <= rd_nxt_s;
            state_r     <= state_nxt_s;
`ifdef LAB_SCHED_TIMEOUT_EN
            timer_r     <= timer_nxt_s;
`endif
            trig_ack_o  <= alloc_s;
            trig_drop_o <= drop_s;
            trig_buf_o  <= alloc_s ? wr_r[1:0] : 2'd0;
            digitize_o  <= digitize_nxt_s;
            rd_valid_o  <= (rd_nxt_s != dg_nxt_s);
            rd_buf_o    <= rd_nxt_s[1:0];
            occupancy_o <= occ_nxt_s;
            full_o      <= (occ_nxt_s == 3'd4);
            drop_cnt_o  <= drop_cnt_nxt_s;
            timeout_o   <= timeout_nxt_s;
            state_o     <= state_nxt_s;
        end
    end

endmodule

// File: tb/tb_lab_buffer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_lab_buffer_scheduler
//
// Drives directed scenarios and then randomized traffic into
// lab_buffer_scheduler. The reference model counts buffers allocated,
// digitized and freed as plain integers. It tracks the digitizer as
// idle / issuing / waiting. Every output is compared against the model on
// each falling edge. A few literal expectations pin the model itself.
// -----------------------------------------------------------------------------
module tb_lab_buffer_scheduler;

    localparam int DIG_TIMEOUT = 16;
    localparam int DROP_W      = 4;
    localparam int DROP_MAX    = (1 << DROP_W) - 1;

    logic              clk_i = 1'b0;
    logic              nrst_i;
    logic              clear_i;
    logic              trig_i;
    logic              trig_ack_o;
    logic              trig_drop_o;
    logic [1:0]        trig_buf_o;
    logic [3:0]        digitize_o;
    logic              dig_done_i;
    logic              rd_valid_o;
    logic [1:0]        rd_buf_o;
    logic              rd_done_i;
    logic [2:0]        occupancy_o;
    logic              full_o;
    logic [DROP_W-1:0] drop_cnt_o;
    logic              timeout_o;
    logic [1:0]        state_o;

    lab_buffer_scheduler #(
        .DIG_TIMEOUT (DIG_TIMEOUT),
        .DROP_W      (DROP_W)
    ) dut (
        .clk_i       (clk_i),
        .nrst_i      (nrst_i),
        .clear_i     (clear_i),
        .trig_i      (trig_i),
        .trig_ack_o  (trig_ack_o),
        .trig_drop_o (trig_drop_o),
        .trig_buf_o  (trig_buf_o),
        .digitize_o  (digitize_o),
        .dig_done_i  (dig_done_i),
        .rd_valid_o  (rd_valid_o),
        .rd_buf_o    (rd_buf_o),
        .rd_done_i   (rd_done_i),
        .occupancy_o (occupancy_o),
        .full_o      (full_o),
        .drop_cnt_o  (drop_cnt_o),
        .timeout_o   (timeout_o),
        .state_o     (state_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_on   = 1'b0;

    // Model: buffer counts since reset, digitizer phase, waiting time
    int n_alloc;
    int n_dig;
    int n_free;
    int phase;      // 0 idle, 1 issuing, 2 waiting
    int wcnt;
    int drops;
    bit tout;
    bit e_ack;
    bit e_drop;
    int e_tbuf;
    int e_dig;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        n_alloc = 0;
        n_dig   = 0;
        n_free  = 0;
        phase   = 0;
        wcnt    = 0;
        drops   = 0;
        tout    = 1'b0;
        e_ack   = 1'b0;
        e_drop  = 1'b0;
        e_tbuf  = 0;
        e_dig   = 0;
    endfunction

    // One rising edge of the model with the inputs that were presented
    function automatic void model_edge(input bit t, input bit d, input bit r, input bit c);
        int occ;
        int na0;
        int nd0;
        if (c) begin
            model_reset();
            return;
        end
        na0    = n_alloc;
        nd0    = n_dig;
        occ    = n_alloc - n_free;
        e_ack  = t && (occ < 4);
        e_drop = t && (occ >= 4);
        e_tbuf = e_ack ? (na0 % 4) : 0;
        if (e_drop && drops < DROP_MAX) drops++;
        if (r && n_free < nd0) n_free++;
        if (e_ack) n_alloc++;
        case (phase)
            0: begin
                if (nd0 < na0) phase = 1;
            end
            1: begin
                phase = 2;
                wcnt  = 0;
            end
            default: begin
                if (d) begin
                    n_dig++;
                    phase = 0;
                end else begin
`ifdef LAB_SCHED_TIMEOUT_EN
                    wcnt++;
                    if (wcnt == DIG_TIMEOUT) begin
                        n_dig++;
                        phase = 0;
                        tout  = 1'b1;
                    end
`endif
                end
            end
        endcase
        e_dig = (phase == 1) ? (1 << (n_dig % 4)) : 0;
    endfunction

    // Compare every output against the model once per cycle
    always @(negedge clk_i) begin
        if (chk_on) begin
            chk("trig_ack",  32'(trig_ack_o),  32'(e_ack));
            chk("trig_drop", 32'(trig_drop_o), 32'(e_drop));
            chk("trig_buf",  32'(trig_buf_o),  32'(e_tbuf));
            chk("digitize",  32'(digitize_o),  32'(e_dig));
            chk("rd_valid",  32'(rd_valid_o),  32'(n_free < n_dig));
            chk("rd_buf",    32'(rd_buf_o),    32'(n_free % 4));
            chk("occupancy", 32'(occupancy_o), 32'(n_alloc - n_free));
            chk("full",      32'(full_o),      32'((n_alloc - n_free) == 4));
            chk("drop_cnt",  32'(drop_cnt_o),  32'(drops));
            chk("timeout",   32'(timeout_o),   32'(tout));
            chk("state",     32'(state_o),     32'(phase));
        end
    end

    task automatic step(input bit t, input bit d, input bit r, input bit c);
        trig_i     = t;
        dig_done_i = d;
        rd_done_i  = r;
        clear_i    = c;
        @(posedge clk_i);
        model_edge(t, d, r, c);
        #1;
        trig_i     = 1'b0;
        dig_done_i = 1'b0;
        rd_done_i  = 1'b0;
        clear_i    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset(input int n);
        #2;
        nrst_i = 1'b0;
        model_reset();
        repeat (n) @(posedge clk_i);
        #1;
        nrst_i = 1'b1;
    endtask

    initial begin
        nrst_i     = 1'b0;
        clear_i    = 1'b0;
        trig_i     = 1'b0;
        dig_done_i = 1'b0;
        rd_done_i  = 1'b0;
        model_reset();
        chk_on = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        nrst_i = 1'b1;

        // Reset state
        chk("t1_state",    32'(state_o),     32'd0);
        chk("t1_occ",      32'(occupancy_o), 32'd0);
        chk("t1_rd_valid", 32'(rd_valid_o),  32'd0);

        // Single trigger through digitize, readout and free
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_ack", 32'(trig_ack_o), 32'd1);
        chk("t2_buf", 32'(trig_buf_o), 32'd0);
        idle(1);
        chk("t2_digitize", 32'(digitize_o), 32'h1);
        idle(1);
        chk("t2_wait", 32'(state_o), 32'd2);
        idle(8);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_rd_valid", 32'(rd_valid_o), 32'd1);
        chk("t2_rd_buf",   32'(rd_buf_o),   32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2_rd_free", 32'(rd_valid_o),  32'd0);
        chk("t2_occ",     32'(occupancy_o), 32'd0);

        // Fill all four buffers, then drop a fifth trigger
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if (k < 4) begin
                chk("t3_buf", 32'(trig_buf_o), 32'(k));
            end else begin
                chk("t3_drop", 32'(trig_drop_o), 32'd1);
            end
            idle(2);
        end
        chk("t3_drop_cnt", 32'(drop_cnt_o), 32'd1);
        chk("t3_full",     32'(full_o),     32'd1);
        for (int j = 0; j < 4; j++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (j < 3) begin
                idle(1);
                chk("t3_digitize", 32'(digitize_o), 32'(1 << (j + 1)));
            end
            idle(2);
        end

        // Trigger and free on the same edge while full
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t4_drop_cnt", 32'(drop_cnt_o),  32'd2);
        chk("t4_occ",      32'(occupancy_o), 32'd3);
        chk("t4_rd_buf",   32'(rd_buf_o),    32'd1);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_empty", 32'(occupancy_o), 32'd0);

        // Digitizer never answers
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(18);
`ifdef LAB_SCHED_TIMEOUT_EN
        chk("t5_rd_valid", 32'(rd_valid_o), 32'd1);
        chk("t5_timeout",  32'(timeout_o),  32'd1);
`else
        chk("t5_state",   32'(state_o),   32'd2);
        chk("t5_timeout", 32'(timeout_o), 32'd0);
`endif
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_occ", 32'(occupancy_o), 32'd0);

        // Asynchronous reset while waiting, late done afterwards
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        pulse_reset(2);
        idle(1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_state",    32'(state_o),     32'd0);
        chk("t6_rd_valid", 32'(rd_valid_o),  32'd0);
        chk("t6_occ",      32'(occupancy_o), 32'd0);

        // Drop counter saturation
        step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (24) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sat_drop_cnt", 32'(drop_cnt_o), 32'(DROP_MAX));
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_drop_cnt", 32'(drop_cnt_o), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                pulse_reset(1 + int'($urandom_range(0, 2)));
            end else begin
                step($urandom_range(0, 99) < 35,
                     $urandom_range(0, 99) < 25,
                     $urandom_range(0, 99) < 30,
                     $urandom_range(0, 499) == 0);
            end
        end
        idle(2);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
